// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths and the state encoding.
package fetch_pkg;

    localparam int AW = 12;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        LATCH = 2'd2,
        VALID = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: drives PC load/increment and fetch-register capture, presents bytes to decode.
// Optional FETCH_SEQ_PERF_EN adds a saturating accepted-instruction counter (fetch_count).
module fetch_sequencer #(
    parameter int            AW         = fetch_pkg::AW,
    parameter logic [AW-1:0] START_ADDR = '0,
    parameter logic [AW-1:0] END_ADDR   = '1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          halt_req,
    input  logic          jump_valid,
    input  logic [AW-1:0] jump_addr,
    input  logic [AW-1:0] pc_q,
    output logic          pc_en,
    output logic          pc_load,
    output logic [AW-1:0] pc_d,
    output logic          fetch_en,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] instr_addr,
    output logic          busy,
    output logic          done
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [15:0]   fetch_count
`endif
);
    import fetch_pkg::*;

    state_t state, state_nxt;
    logic   done_nxt;
    logic   accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            instr_addr <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (fetch_en)
                instr_addr <= pc_q;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        pc_load     = 1'b0;
        pc_d        = START_ADDR;
        fetch_en    = 1'b0;
        instr_valid = 1'b0;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !halt_req) begin
                    pc_load   = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR:  state_nxt = LATCH;
            LATCH: begin
                // PC is bumped while the ROM output is captured, so it already
                // points at the next byte by the time decode takes this one.
                fetch_en  = 1'b1;
                pc_en     = 1'b1;
                state_nxt = VALID;
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (instr_addr == END_ADDR) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LATCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Jump drops any presented instruction without a handshake and wins over END_ADDR.
        if (jump_valid && state != IDLE) begin
            pc_load     = 1'b1;
            pc_d        = jump_addr;
            pc_en       = 1'b0;
            fetch_en    = 1'b0;
            instr_valid = 1'b0;
            done_nxt    = 1'b0;
            state_nxt   = ADDR;
        end

        if (halt_req) begin
            pc_load     = 1'b0;
            pc_d        = START_ADDR;
            pc_en       = 1'b0;
            fetch_en    = 1'b0;
            instr_valid = 1'b0;
            done_nxt    = 1'b0;
            state_nxt   = IDLE;
        end
    end

    assign busy   = (state != IDLE);
    assign accept = instr_valid && instr_ready;

`ifdef FETCH_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fetch_count <= '0;
        else if (state == IDLE && start)
            fetch_count <= '0;
        else if (accept && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC, ROM (m[i]=i[7:0]) and fetch register models around the DUT,
// handshakes checked by a scoreboard monitor, control outputs checked directly.
module tb_fetch_sequencer;

    localparam logic [11:0] END_A = 12'h00A;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        jump_valid = 1'b0;
    logic [11:0] jump_addr = '0;
    logic [11:0] pc_q = '0;
    logic        pc_en, pc_load, fetch_en, instr_valid, busy, done;
    logic [11:0] pc_d, instr_addr;
    logic        instr_ready = 1'b0;
    logic [15:0] fetch_count;
    logic [7:0]  freg = '0;
    logic [7:0]  rom [4096];

    int n_chk = 0;
    int n_fail = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_sequencer #(.START_ADDR(12'h000), .END_ADDR(END_A)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .jump_valid(jump_valid), .jump_addr(jump_addr), .pc_q(pc_q),
        .pc_en(pc_en), .pc_load(pc_load), .pc_d(pc_d), .fetch_en(fetch_en),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_addr(instr_addr),
        .busy(busy), .done(done)
`ifdef FETCH_SEQ_PERF_EN
        , .fetch_count(fetch_count)
`endif
    );

`ifndef FETCH_SEQ_PERF_EN
    assign fetch_count = '0;
`endif

    initial for (int i = 0; i < 4096; i++) rom[i] = i[7:0];

    // External datapath: not reset by the sequencer's reset.
    always @(posedge clk) begin
        if (pc_load)     pc_q <= pc_d;
        else if (pc_en)  pc_q <= pc_q + 12'd1;
        if (fetch_en)    freg <= rom[pc_q];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL handshake: unexpected addr %0h byte %0h", instr_addr, freg);
            end else begin
                chk("handshake", {12'h0, instr_addr, freg}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic push(input logic [11:0] a);
        exp_q.push_back({a, a[7:0]});
    endtask

    task automatic wait_valid(input logic [11:0] a);
        bit hit = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid && instr_addr == a) begin
                hit = 1;
                break;
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_valid: no instr_valid at addr %0h within 60 cycles", a);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_ctrl", {pc_en, pc_load, fetch_en, done}, 0);
        chk("rst_pc_d", pc_d, 12'h000);
        chk("rst_addr", instr_addr, 0);
        reset = 1'b1;

        // sequential run, first-instruction latency
        for (int i = 0; i < 7; i++) push(i[11:0]);
        step();
        start = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        chk("start_load", {pc_load, pc_d}, {1'b1, 12'h000});
        step();
        start = 1'b0;
        @(negedge clk);
        chk("addr_state", {busy, instr_valid, fetch_en, pc_en}, 4'b1000);
        @(negedge clk);
        chk("latch_state", {instr_valid, fetch_en, pc_en}, 3'b011);
        @(negedge clk);
        chk("first_valid", {instr_valid, instr_addr}, {1'b1, 12'h000});

        // decode stall at addr 4
        wait_valid(12'h003);
        step();
        instr_ready = 1'b0;
        wait_valid(12'h004);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {instr_valid, instr_addr, freg}, {1'b1, 12'h004, 8'h04});
            chk("stall_pc", pc_q, 12'h005);
            @(negedge clk);
        end
        step();
        instr_ready = 1'b1;

        // jump while presenting addr 7
        wait_valid(12'h006);
        @(posedge clk);
        step();
        jump_valid = 1'b1; jump_addr = 12'h100;
        @(negedge clk);
        chk("jump_addr7", instr_addr, 12'h007);
        chk("jump_ctrl", {instr_valid, pc_load, pc_en, fetch_en, pc_d}, {4'b0100, 12'h100});
        push(12'h100);
        step();
        jump_valid = 1'b0;
        @(negedge clk);
        chk("jump_drop", instr_valid, 0);
        wait_valid(12'h100);

        // halt + jump together in LATCH
        step();
        halt_req = 1'b1; jump_valid = 1'b1; jump_addr = 12'h200;
        @(negedge clk);
        chk("halt_ctrl", {pc_load, pc_en, fetch_en, instr_valid}, 4'b0000);
        step();
        halt_req = 1'b0; jump_valid = 1'b0;
        @(negedge clk);
        chk("halt_idle", {busy, instr_valid}, 2'b00);
        chk("halt_pc", pc_q, 12'h101);
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_count", fetch_count, 16'd8);
`endif

        // reset mid-VALID
        step();
        instr_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(12'h000);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid", {instr_valid, busy, pc_load}, 3'b000);
        chk("rst_mid_pc", pc_q, 12'h001);
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_rst", fetch_count, 16'd0);
`endif
        @(negedge clk);
        #2 reset = 1'b1;

        // PC wrap run ending at END_A
        push(12'hFFE); push(12'hFFF);
        for (int i = 0; i <= 10; i++) push(i[11:0]);
        step();
        start = 1'b1; instr_ready = 1'b1;
        step();
        start = 1'b0; jump_valid = 1'b1; jump_addr = 12'hFFE;
        step();
        jump_valid = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (done) begin seen = 1; break; end
            end
            chk("done_pulse", seen, 1);
        end
        chk("done_state", {busy, instr_valid, pc_en}, 3'b000);
        @(negedge clk);
        chk("done_once", {done, pc_en, busy}, 3'b000);
        chk("end_pc", pc_q, 12'h00B);
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_wrap", fetch_count, 16'd13);
`endif
        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
